// File: rtl/scanline_gen.sv
`default_nettype none
// ============================================================================
// Module   : scanline_gen
// Purpose  : Row/column scanline overlay on the scanconverter pixel stream.
//            Darkens pixels by a 4-bit strength, with a fixed 3-cycle latency.
//            Optional macro SCANLINE_ALT_FIELD_EN enables the alternating-field
//            row phase shift.
// Revision : 1.0 - initial release
// ============================================================================
module scanline_gen #(
    parameter int LATENCY = 3
) (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic [7:0]  R_i,
    input  logic [7:0]  G_i,
    input  logic [7:0]  B_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    input  logic [10:0] xpos_i,
    input  logic [10:0] ypos_i,
    input  logic [31:0] sl_config,
    input  logic [31:0] sl_config2,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic [10:0] xpos_o,
    output logic [10:0] ypos_o
);

    localparam logic [24:0] c_ctl_reset = {1'b1, 1'b1, 1'b0, 22'd0};

    logic        r_vs_prev;
    logic        r_de_prev;
    logic [10:0] r_last_ypos;
    logic [2:0]  r_row_phase;
    logic [2:0]  r_col_phase;
    logic [18:0] r_sh_row;
    logic [18:0] r_sh_col;

    logic        w_vs_fall;
    logic        w_line_start;
    logic        w_field;
    logic [2:0]  w_row_load;
    logic [2:0]  w_row_next;
    logic [2:0]  w_col_next;
    logic        w_row_hit;
    logic        w_col_hit;
    logic [3:0]  w_str;
    logic        w_unused_cfg;

    logic        r_s1_hit;
    logic [3:0]  r_s1_str;
    logic [23:0] r_s1_pix;
    logic [4:0]  w_s1_mult;
    logic        r_s2_hit;
    logic [23:0] r_s2_pix;
    logic [8:0]  r_s2_dark [3];
    logic [23:0] r_out_pix;
    logic [24:0] r_ctl [LATENCY];

    function automatic logic [2:0] f_reduce(input logic [2:0] v, input logic [2:0] pm1);
        return (v > pm1) ? (v - pm1 - 3'd1) : v;
    endfunction

    function automatic logic [2:0] f_advance(input logic [2:0] v, input logic [2:0] pm1);
        return (v >= pm1) ? 3'd0 : (v + 3'd1);
    endfunction

    assign w_vs_fall    = r_vs_prev & ~VSYNC_i;
    assign w_line_start = DE_i & ~r_de_prev;

`ifdef SCANLINE_ALT_FIELD_EN
    logic r_sh_alt;
    logic r_field;

    // Toggle decision uses the shadow ALT bit held before this VSYNC edge.
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_sh_alt <= 1'b0;
            r_field  <= 1'b0;
        end else begin
            if (w_vs_fall) begin
                r_sh_alt <= sl_config2[19];
            end
            if (!r_sh_alt) begin
                r_field <= 1'b0;
            end else if (w_vs_fall) begin
                r_field <= ~r_field;
            end
        end
    end

    assign w_field      = r_field;
    assign w_unused_cfg = ^{sl_config[31:19], sl_config2[31:20]};
`else
    assign w_field      = 1'b0;
    assign w_unused_cfg = ^{sl_config[31:19], sl_config2[31:19]};
`endif

    // Hits use the phase this pixel lands on, i.e. the counters' next state.
    always_comb begin
        w_row_load = f_reduce(r_sh_row[17:15], r_sh_row[14:12]);
        if (w_field) begin
            w_row_load = f_advance(w_row_load, r_sh_row[14:12]);
        end

        w_row_next = r_row_phase;
        if (w_line_start) begin
            if (ypos_i == 11'd0) begin
                w_row_next = w_row_load;
            end else if (ypos_i != r_last_ypos) begin
                w_row_next = f_advance(r_row_phase, r_sh_row[14:12]);
            end
        end

        w_col_next = r_col_phase;
        if (DE_i) begin
            if (xpos_i == 11'd0) begin
                w_col_next = f_reduce(r_sh_col[17:15], r_sh_col[14:12]);
            end else begin
                w_col_next = f_advance(r_col_phase, r_sh_col[14:12]);
            end
        end

        w_row_hit = DE_i & r_sh_row[18] & r_sh_row[4 + w_row_next];
        w_col_hit = DE_i & r_sh_col[18] & r_sh_col[4 + w_col_next];

        w_str = 4'd0;
        if (w_row_hit) begin
            w_str = r_sh_row[3:0];
        end
        if (w_col_hit && (!w_row_hit || (r_sh_col[3:0] > r_sh_row[3:0]))) begin
            w_str = r_sh_col[3:0];
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_vs_prev   <= 1'b1;
            r_de_prev   <= 1'b0;
            r_last_ypos <= 11'd0;
            r_row_phase <= 3'd0;
            r_col_phase <= 3'd0;
            r_sh_row    <= 19'd0;
            r_sh_col    <= 19'd0;
        end else begin
            r_vs_prev   <= VSYNC_i;
            r_de_prev   <= DE_i;
            r_row_phase <= w_row_next;
            r_col_phase <= w_col_next;
            if (w_line_start) begin
                r_last_ypos <= ypos_i;
            end
            if (w_vs_fall) begin
                r_sh_row <= sl_config[18:0];
                r_sh_col <= sl_config2[18:0];
            end
        end
    end

    assign w_s1_mult = {1'b0, r_s1_str} + 5'd1;

    // Stage 2 keeps only prod[12:4]; prod never exceeds 16*in, so in - that is >= 0.
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_s1_hit  <= 1'b0;
            r_s1_str  <= 4'd0;
            r_s1_pix  <= 24'd0;
            r_s2_hit  <= 1'b0;
            r_s2_pix  <= 24'd0;
            r_out_pix <= 24'd0;
            for (int c = 0; c < 3; c++) begin
                r_s2_dark[c] <= 9'd0;
            end
            for (int i = 0; i < LATENCY; i++) begin
                r_ctl[i] <= c_ctl_reset;
            end
        end else begin
            r_s1_hit <= w_row_hit | w_col_hit;
            r_s1_str <= w_str;
            r_s1_pix <= {R_i, G_i, B_i};
            r_s2_hit <= r_s1_hit;
            r_s2_pix <= r_s1_pix;
            for (int c = 0; c < 3; c++) begin
                r_s2_dark[c] <= 9'(({5'd0, r_s1_pix[c*8 +: 8]} * {8'd0, w_s1_mult}) >> 4);
                r_out_pix[c*8 +: 8] <= r_s2_hit ?
                    8'({1'b0, r_s2_pix[c*8 +: 8]} - r_s2_dark[c]) : r_s2_pix[c*8 +: 8];
            end
            r_ctl[0] <= {HSYNC_i, VSYNC_i, DE_i, xpos_i, ypos_i};
            for (int i = 1; i < LATENCY; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
        end
    end

    assign R_o = r_out_pix[23:16];
    assign G_o = r_out_pix[15:8];
    assign B_o = r_out_pix[7:0];
    assign {HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o} = r_ctl[LATENCY-1];

endmodule
`default_nettype wire
